// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of the single-port CPU memory between the CPU controller and the host loader
module mem_port_arbiter #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_lock,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    logic [1:0]    state;
    logic          owner, last_owner, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, cpu_q, host_q;
    logic          cpu_el, pick, issue, done;
    // owner encoding: 1 = host, 0 = cpu; last_owner starts at host so the CPU wins the first tie
    assign cpu_el = cpu_req & ~host_lock;
    assign pick   = (host_req & cpu_el) ? ~last_owner : host_req;
    assign issue  = state == ISSUE;
    assign done   = state == DONE;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            we         <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            cpu_q      <= '0;
            host_q     <= '0;
        end else begin
            case (state)
                IDLE: if (host_req | cpu_el) begin
                    owner <= pick;
                    we    <= pick ? host_we : cpu_we;
                    addr  <= pick ? host_addr : cpu_addr;
                    wdata <= pick ? host_wdata : cpu_wdata;
                    state <= ISSUE;
                end
                ISSUE: state <= DONE;
                DONE: begin
                    last_owner <= owner;
                    if (!we && owner) host_q <= mem_rdata;
                    if (!we && !owner) cpu_q <= mem_rdata;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // read data bypasses the holding register during DONE so it is visible together with ack
    assign cpu_ack    = done & ~owner;
    assign host_ack   = done & owner;
    assign cpu_rdata  = (cpu_ack & ~we) ? mem_rdata : cpu_q;
    assign host_rdata = (host_ack & ~we) ? mem_rdata : host_q;
    assign cpu_stall  = cpu_req & ~cpu_ack;
    assign mem_addr   = issue ? addr : '0;
    assign mem_wdata  = issue ? wdata : '0;
    assign mem_rd     = issue & ~we;
    assign mem_wr     = issue & we;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed checking of mem_port_arbiter against a transaction-timeline model
module tb_mem_port_arbiter;
    localparam int AW = 5;
    localparam int DW = 8;
    logic          clk = 1'b0, rst = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0, host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
    logic [AW-1:0] cpu_addr = '0, host_addr = '0, mem_addr;
    logic [DW-1:0] cpu_wdata = '0, host_wdata = '0, mem_wdata, cpu_rdata, host_rdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          cpu_ack, host_ack, cpu_stall, mem_rd, mem_wr;
    always #5 clk = ~clk;
    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_lock(host_lock), .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata)
    );
    logic [DW-1:0] mem [32];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end
    // reference: grant at edge g puts the strobe in cycle g, the ack in cycle g+1, next grant no earlier than edge g+3
    logic [DW-1:0] ref_mem [32];
    int            k = 0, g = -1000;
    logic          t_host = 1'b0, t_we = 1'b0, last_host = 1'b1;
    logic [AW-1:0] t_addr = '0;
    logic [DW-1:0] t_wdata = '0, rd_val = '0, held_cpu = '0, held_host = '0;
    logic          e_cack = 1'b0, e_hack = 1'b0;
    int            n_cmp = 0, n_bad = 0, cpu_acks = 0, host_acks = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, k, got, exp);
        end
    endtask
    task automatic model_reset();
        g = -1000;
        last_host = 1'b1;
        held_cpu = '0;
        held_host = '0;
    endtask
    task automatic cycle();
        logic ce, gh, is_i;
        @(posedge clk);
        k++;
        if (!rst) model_reset();
        else begin
            if (k == g + 1) begin
                if (t_we) ref_mem[t_addr] = t_wdata;
                else rd_val = ref_mem[t_addr];
            end
            if (k == g + 2 && !t_we) begin
                if (t_host) held_host = rd_val;
                else held_cpu = rd_val;
            end
            ce = cpu_req && !host_lock;
            if (k >= g + 3 && (ce || host_req)) begin
                gh = (ce && host_req) ? !last_host : host_req;
                g = k;
                t_host = gh;
                last_host = gh;
                t_we = gh ? host_we : cpu_we;
                t_addr = gh ? host_addr : cpu_addr;
                t_wdata = gh ? host_wdata : cpu_wdata;
            end
        end
        @(negedge clk);
        is_i = (k == g);
        e_cack = (k == g + 1) && !t_host;
        e_hack = (k == g + 1) && t_host;
        check("mem_rd", 32'(mem_rd), 32'(is_i && !t_we));
        check("mem_wr", 32'(mem_wr), 32'(is_i && t_we));
        check("mem_addr", 32'(mem_addr), is_i ? 32'(t_addr) : 32'd0);
        check("mem_wdata", 32'(mem_wdata), is_i ? 32'(t_wdata) : 32'd0);
        check("cpu_ack", 32'(cpu_ack), 32'(e_cack));
        check("host_ack", 32'(host_ack), 32'(e_hack));
        check("cpu_rdata", 32'(cpu_rdata), (e_cack && !t_we) ? 32'(rd_val) : 32'(held_cpu));
        check("host_rdata", 32'(host_rdata), (e_hack && !t_we) ? 32'(rd_val) : 32'(held_host));
        check("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !e_cack));
        if (cpu_ack) cpu_acks++;
        if (host_ack) host_acks++;
    endtask
    task automatic rand_cpu();
        cpu_req = 1'($urandom_range(1));
        cpu_we = 1'($urandom_range(1));
        cpu_addr = AW'($urandom);
        cpu_wdata = DW'($urandom);
    endtask
    task automatic rand_host();
        host_req = 1'($urandom_range(1));
        host_we = 1'($urandom_range(1));
        host_addr = AW'($urandom);
        host_wdata = DW'($urandom);
    endtask
    initial begin
        int own[$], at[$];
        int n0;
        logic got;
        logic [DW-1:0] rv;
        for (int i = 0; i < 32; i++) begin
            mem[i] = DW'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[10] = 8'h3C; ref_mem[10] = 8'h3C;
        mem[3] = 8'h11;  ref_mem[3] = 8'h11;
        // reset held with random requests, then idle after release
        for (int i = 0; i < 6; i++) begin
            rand_cpu();
            rand_host();
            cycle();
        end
        cpu_req = 1'b0; host_req = 1'b0; rst = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        // single CPU read of 0x0A
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h0A;
        cycle();
        check("t2_mem_rd", 32'(mem_rd), 32'd1);
        check("t2_mem_addr", 32'(mem_addr), 32'h0A);
        check("t2_stall", 32'(cpu_stall), 32'd1);
        cycle();
        check("t2_ack", 32'(cpu_ack), 32'd1);
        check("t2_rdata", 32'(cpu_rdata), 32'h3C);
        cpu_req = 1'b0;
        cycle();
        check("t2_rdata_hold", 32'(cpu_rdata), 32'h3C);
        // both requesting from reset release: CPU first, then alternate
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h05;
        host_req = 1'b1; host_we = 1'b0; host_addr = 5'h06;
        cycle();
        rst = 1'b1;
        for (int i = 0; i < 13; i++) begin
            cycle();
            if (cpu_ack || host_ack) begin
                own.push_back(int'(host_ack));
                at.push_back(k);
            end
        end
        check("t3_ack_count", 32'(own.size()), 32'd4);
        for (int i = 0; i < own.size() && i < 4; i++) begin
            check("t3_owner", 32'(own[i]), 32'(i % 2));
            if (i > 0) check("t3_spacing", 32'(at[i] - at[i-1]), 32'd3);
        end
        cpu_req = 1'b0; host_req = 1'b0;
        cycle(); cycle(); cycle();
        // host lock keeps the CPU out while the host writes
        host_lock = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h02;
        host_req = 1'b1; host_we = 1'b1; host_addr = 5'h1F; host_wdata = 8'hA5;
        n0 = cpu_acks;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (e_hack) host_req = 1'b0;
        end
        check("t4_no_cpu_ack", 32'(cpu_acks - n0), 32'd0);
        check("t4_stall", 32'(cpu_stall), 32'd1);
        host_lock = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            cycle();
            got = cpu_ack;
        end
        check("t4_cpu_after_unlock", 32'(got), 32'd1);
        cpu_req = 1'b0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 5'h1F;
        got = 1'b0;
        rv = '0;
        for (int i = 0; i < 6 && !got; i++) begin
            cycle();
            got = host_ack;
            rv = host_rdata;
        end
        host_req = 1'b0;
        check("t4_host_ack", 32'(got), 32'd1);
        check("t4_readback", 32'(rv), 32'hA5);
        cycle(); cycle();
        // reset during a host write's strobe cycle
        host_req = 1'b1; host_we = 1'b1; host_addr = 5'h03; host_wdata = 8'h77;
        cycle();
        check("t5_wr_strobe", 32'(mem_wr), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("t5_wr_drop", 32'(mem_wr), 32'd0);
        check("t5_no_ack", 32'(host_ack), 32'd0);
        host_req = 1'b0;
        n0 = host_acks;
        cycle(); cycle();
        rst = 1'b1;
        cycle(); cycle();
        check("t5_no_ack_after", 32'(host_acks - n0), 32'd0);
        check("t5_mem_kept", 32'(mem[3]), 32'h11);
        // one-cycle CPU pulse still completes once
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h03;
        n0 = cpu_acks;
        cycle();
        cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check("t6_single_ack", 32'(cpu_acks - n0), 32'd1);
        check("t6_rdata", 32'(cpu_rdata), 32'h11);
        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            cycle();
            if (e_cack || (!cpu_req && $urandom_range(3) == 0) || $urandom_range(19) == 0) rand_cpu();
            if (e_hack || (!host_req && $urandom_range(3) == 0) || $urandom_range(19) == 0) rand_host();
            if ($urandom_range(15) == 0) host_lock = ~host_lock;
        end
        for (int i = 0; i < 32; i++) check("final_mem", 32'(mem[i]), 32'(ref_mem[i]));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
